// File: rtl/pipeline_pkg.sv
// Shared widths and the WB control bundle used by all stage latches.
// The bubble constant is the all-zero control bundle.
package pipeline_pkg;

  localparam int DEF_NB_ADDR = 32;
  localparam int DEF_NB_DATA = 32;
  localparam int DEF_NB_PC   = 32;
  localparam int DEF_NB_REG  = 5;
  localparam int DEF_NB_CNT  = 32;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_to_reg;
    logic r31_ctrl;
  } wb_ctrl_t;

  localparam wb_ctrl_t WB_BUBBLE = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
// It stops at all-ones instead of wrapping around.
module sat_counter #(
  parameter int NB_CNT = 32
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_inc,
  output logic [NB_CNT-1:0] o_count
);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_count <= '0;
    end else if (i_inc && !(&o_count)) begin
      o_count <= o_count + NB_CNT'(1);
    end
  end

endmodule

// File: rtl/mem_wb_latch.sv
// MEM/WB pipeline register with bubble insertion, debug hold,
// sticky halt detection and a saturating retired-instruction counter.
module mem_wb_latch
  import pipeline_pkg::*;
#(
  parameter int NB_ADDR = DEF_NB_ADDR,
  parameter int NB_DATA = DEF_NB_DATA,
  parameter int NB_PC   = DEF_NB_PC,
  parameter int NB_REG  = DEF_NB_REG,
  parameter int NB_CNT  = DEF_NB_CNT
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_flush,
  input  logic               i_MEM_valid,
  input  logic               i_MEM_halt,
  input  logic [NB_DATA-1:0] i_MEM_mem_data,
  input  logic [NB_ADDR-1:0] i_MEM_alu_result,
  input  logic [NB_REG-1:0]  i_MEM_selected_reg,
  input  logic               i_MEM_reg_write,
  input  logic               i_MEM_mem_to_reg,
  input  logic               i_MEM_r31_ctrl,
  input  logic [NB_PC-1:0]   i_MEM_pc,
  output logic [NB_DATA-1:0] o_WB_mem_data,
  output logic [NB_ADDR-1:0] o_WB_alu_result,
  output logic [NB_REG-1:0]  o_WB_selected_reg,
  output logic               o_WB_reg_write,
  output logic               o_WB_mem_to_reg,
  output logic               o_WB_r31_ctrl,
  output logic [NB_PC-1:0]   o_WB_pc,
  output logic               o_WB_valid,
  output logic               o_halt_done,
  output logic [NB_CNT-1:0]  o_retired_count
);

  wb_ctrl_t ctrl_q;
  logic     halt_q;
  logic     adv;
  logic     capture;

  // Once HALT has retired the whole latch freezes until reset.
  assign adv     = i_enable & ~halt_q;
  assign capture = adv & ~i_flush & i_MEM_valid;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      ctrl_q            <= WB_BUBBLE;
      o_WB_mem_data     <= '0;
      o_WB_alu_result   <= '0;
      o_WB_selected_reg <= '0;
      o_WB_pc           <= '0;
      halt_q            <= 1'b0;
    end else if (adv) begin
      if (capture) begin
        ctrl_q.valid      <= 1'b1;
        ctrl_q.reg_write  <= i_MEM_reg_write;
        ctrl_q.mem_to_reg <= i_MEM_mem_to_reg;
        ctrl_q.r31_ctrl   <= i_MEM_r31_ctrl;
        o_WB_mem_data     <= i_MEM_mem_data;
        o_WB_alu_result   <= i_MEM_alu_result;
        o_WB_selected_reg <= i_MEM_selected_reg;
        o_WB_pc           <= i_MEM_pc;
        halt_q            <= i_MEM_halt;
      end else begin
        ctrl_q            <= WB_BUBBLE;
        o_WB_mem_data     <= '0;
        o_WB_alu_result   <= '0;
        o_WB_selected_reg <= '0;
        o_WB_pc           <= '0;
      end
    end
  end

  sat_counter #(
    .NB_CNT(NB_CNT)
  ) u_retired (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_inc  (capture),
    .o_count(o_retired_count)
  );

  assign o_WB_valid      = ctrl_q.valid;
  assign o_WB_reg_write  = ctrl_q.reg_write;
  assign o_WB_mem_to_reg = ctrl_q.mem_to_reg;
  assign o_WB_r31_ctrl   = ctrl_q.r31_ctrl;
  assign o_halt_done     = halt_q;

endmodule

// File: tb/tb_mem_wb_latch.sv
// Self-checking bench for mem_wb_latch: directed vector table, async reset,
// randomized run against a rule-level model, and counter saturation at NB_CNT=4.
module tb_mem_wb_latch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_sat = 1'b1;
  logic        en, fl, v, h, rw, m2r, r31;
  logic [31:0] md, alu, pc;
  logic [4:0]  sreg;

  logic [31:0] wb_md, wb_alu, wb_pc, wb_cnt;
  logic [4:0]  wb_sreg;
  logic        wb_rw, wb_m2r, wb_r31, wb_valid, wb_hd;

  logic [31:0] s_md, s_alu, s_pc;
  logic [4:0]  s_sreg;
  logic        s_rw, s_m2r, s_r31, s_valid, s_hd;
  logic [3:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_latch dut (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_flush(fl),
    .i_MEM_valid(v), .i_MEM_halt(h), .i_MEM_mem_data(md),
    .i_MEM_alu_result(alu), .i_MEM_selected_reg(sreg),
    .i_MEM_reg_write(rw), .i_MEM_mem_to_reg(m2r), .i_MEM_r31_ctrl(r31),
    .i_MEM_pc(pc),
    .o_WB_mem_data(wb_md), .o_WB_alu_result(wb_alu),
    .o_WB_selected_reg(wb_sreg), .o_WB_reg_write(wb_rw),
    .o_WB_mem_to_reg(wb_m2r), .o_WB_r31_ctrl(wb_r31), .o_WB_pc(wb_pc),
    .o_WB_valid(wb_valid), .o_halt_done(wb_hd), .o_retired_count(wb_cnt)
  );

  mem_wb_latch #(.NB_CNT(4)) dut_sat (
    .i_clock(clk), .i_reset(rst_sat), .i_enable(en), .i_flush(fl),
    .i_MEM_valid(v), .i_MEM_halt(h), .i_MEM_mem_data(md),
    .i_MEM_alu_result(alu), .i_MEM_selected_reg(sreg),
    .i_MEM_reg_write(rw), .i_MEM_mem_to_reg(m2r), .i_MEM_r31_ctrl(r31),
    .i_MEM_pc(pc),
    .o_WB_mem_data(s_md), .o_WB_alu_result(s_alu),
    .o_WB_selected_reg(s_sreg), .o_WB_reg_write(s_rw),
    .o_WB_mem_to_reg(s_m2r), .o_WB_r31_ctrl(s_r31), .o_WB_pc(s_pc),
    .o_WB_valid(s_valid), .o_halt_done(s_hd), .o_retired_count(s_cnt)
  );

  typedef struct packed {
    logic        en, fl, v, h;
    logic [31:0] md, alu;
    logic [4:0]  sreg;
    logic        rw, m2r, r31;
    logic [31:0] pc;
    logic [31:0] e_md, e_alu;
    logic [4:0]  e_sreg;
    logic        e_rw, e_m2r, e_r31;
    logic [31:0] e_pc;
    logic        e_valid, e_hd;
    logic [31:0] e_cnt;
  } vec_t;

  // What WB should show, tracked from the block's rules.
  typedef struct {
    logic [31:0] md, alu, pc;
    logic [4:0]  sreg;
    logic        rw, m2r, r31, valid, hd;
    longint      cnt;
  } model_t;

  model_t m;
  vec_t   vecs[12];

  function automatic vec_t mkvec(
      logic en_, fl_, v_, h_, logic [31:0] md_, alu_, logic [4:0] sreg_,
      logic rw_, m2r_, r31_, logic [31:0] pc_,
      logic [31:0] emd, ealu, logic [4:0] esreg, logic erw, em2r, er31,
      logic [31:0] epc, logic evalid, ehd, logic [31:0] ecnt);
    vec_t r;
    r.en = en_; r.fl = fl_; r.v = v_; r.h = h_; r.md = md_; r.alu = alu_;
    r.sreg = sreg_; r.rw = rw_; r.m2r = m2r_; r.r31 = r31_; r.pc = pc_;
    r.e_md = emd; r.e_alu = ealu; r.e_sreg = esreg; r.e_rw = erw;
    r.e_m2r = em2r; r.e_r31 = er31; r.e_pc = epc; r.e_valid = evalid;
    r.e_hd = ehd; r.e_cnt = ecnt;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t t);
    en = t.en; fl = t.fl; v = t.v; h = t.h; md = t.md; alu = t.alu;
    sreg = t.sreg; rw = t.rw; m2r = t.m2r; r31 = t.r31; pc = t.pc;
    tick();
  endtask

  task automatic checkVector(input string tag, input vec_t t);
    checkOutput({tag, " mem_data"},   wb_md,    t.e_md);
    checkOutput({tag, " alu_result"}, wb_alu,   t.e_alu);
    checkOutput({tag, " sel_reg"},    wb_sreg,  t.e_sreg);
    checkOutput({tag, " reg_write"},  wb_rw,    t.e_rw);
    checkOutput({tag, " mem_to_reg"}, wb_m2r,   t.e_m2r);
    checkOutput({tag, " r31_ctrl"},   wb_r31,   t.e_r31);
    checkOutput({tag, " pc"},         wb_pc,    t.e_pc);
    checkOutput({tag, " valid"},      wb_valid, t.e_valid);
    checkOutput({tag, " halt_done"},  wb_hd,    t.e_hd);
    checkOutput({tag, " count"},      wb_cnt,   t.e_cnt);
  endtask

  task automatic modelReset();
    m.md = 0; m.alu = 0; m.pc = 0; m.sreg = 0;
    m.rw = 0; m.m2r = 0; m.r31 = 0; m.valid = 0; m.hd = 0; m.cnt = 0;
  endtask

  // One clock edge described by the rules: hold, bubble or capture.
  task automatic modelStep();
    if (en && !m.hd) begin
      if (fl || !v) begin
        m.md = 0; m.alu = 0; m.pc = 0; m.sreg = 0;
        m.rw = 0; m.m2r = 0; m.r31 = 0; m.valid = 0;
      end else begin
        m.md = md; m.alu = alu; m.pc = pc; m.sreg = sreg;
        m.rw = rw; m.m2r = m2r; m.r31 = r31; m.valid = 1;
        if (m.cnt < 64'hFFFF_FFFF) m.cnt = m.cnt + 1;
        if (h) m.hd = 1;
      end
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, " mem_data"},   wb_md,    m.md);
    checkOutput({tag, " alu_result"}, wb_alu,   m.alu);
    checkOutput({tag, " sel_reg"},    wb_sreg,  m.sreg);
    checkOutput({tag, " reg_write"},  wb_rw,    m.rw);
    checkOutput({tag, " mem_to_reg"}, wb_m2r,   m.m2r);
    checkOutput({tag, " r31_ctrl"},   wb_r31,   m.r31);
    checkOutput({tag, " pc"},         wb_pc,    m.pc);
    checkOutput({tag, " valid"},      wb_valid, m.valid);
    checkOutput({tag, " halt_done"},  wb_hd,    m.hd);
    checkOutput({tag, " count"},      wb_cnt,   m.cnt);
  endtask

  initial begin
    //            en fl v  h  md     alu    reg rw m2r r31 pc      | e_md   e_alu  reg rw m2r r31 e_pc  val hd cnt
    vecs[0]  = mkvec(1, 0, 1, 0, 32'h11, 32'h2A, 3,  1, 0, 0, 32'h04, 32'h11, 32'h2A, 3,  1, 0, 0, 32'h04, 1, 0, 1);
    vecs[1]  = mkvec(0, 0, 1, 0, 32'h99, 32'h55, 7,  1, 1, 1, 32'h08, 32'h11, 32'h2A, 3,  1, 0, 0, 32'h04, 1, 0, 1);
    vecs[2]  = mkvec(0, 1, 1, 0, 32'h98, 32'h56, 8,  1, 1, 1, 32'h0C, 32'h11, 32'h2A, 3,  1, 0, 0, 32'h04, 1, 0, 1);
    vecs[3]  = mkvec(0, 0, 0, 0, 32'h97, 32'h57, 9,  0, 0, 0, 32'h0E, 32'h11, 32'h2A, 3,  1, 0, 0, 32'h04, 1, 0, 1);
    vecs[4]  = mkvec(1, 1, 1, 0, 32'h96, 32'h58, 10, 1, 1, 1, 32'h10, 32'h00, 32'h00, 0,  0, 0, 0, 32'h00, 0, 0, 1);
    vecs[5]  = mkvec(1, 0, 1, 0, 32'h77, 32'h3C, 31, 1, 1, 1, 32'h14, 32'h77, 32'h3C, 31, 1, 1, 1, 32'h14, 1, 0, 2);
    vecs[6]  = mkvec(1, 0, 0, 0, 32'h76, 32'h3D, 5,  1, 1, 0, 32'h18, 32'h00, 32'h00, 0,  0, 0, 0, 32'h00, 0, 0, 2);
    vecs[7]  = mkvec(1, 1, 1, 1, 32'h75, 32'h3E, 6,  0, 0, 0, 32'h1C, 32'h00, 32'h00, 0,  0, 0, 0, 32'h00, 0, 0, 2);
    vecs[8]  = mkvec(1, 0, 1, 1, 32'h00, 32'h00, 0,  0, 0, 0, 32'h20, 32'h00, 32'h00, 0,  0, 0, 0, 32'h20, 1, 1, 3);
    vecs[9]  = mkvec(1, 0, 1, 0, 32'h74, 32'h3F, 12, 1, 1, 1, 32'h24, 32'h00, 32'h00, 0,  0, 0, 0, 32'h20, 1, 1, 3);
    vecs[10] = mkvec(1, 1, 1, 0, 32'h73, 32'h40, 13, 1, 0, 1, 32'h28, 32'h00, 32'h00, 0,  0, 0, 0, 32'h20, 1, 1, 3);
    vecs[11] = mkvec(0, 0, 1, 0, 32'h72, 32'h41, 14, 1, 0, 1, 32'h2C, 32'h00, 32'h00, 0,  0, 0, 0, 32'h20, 1, 1, 3);

    en = 0; fl = 0; v = 0; h = 0; md = 0; alu = 0; sreg = 0;
    rw = 0; m2r = 0; r31 = 0; pc = 0;
    modelReset();
    tick();
    tick();
    checkModel("reset");
    rst = 1'b0;
    $display("[TB] directed vector table");

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      checkVector($sformatf("vec%0d", i), vecs[i]);
    end

    // Asynchronous reset mid-run, with pc=0x10 and count=5 showing.
    $display("[TB] async reset mid-run");
    rst = 1'b1; #1; rst = 1'b0;
    en = 1; fl = 0; v = 1; h = 0; rw = 1; m2r = 0; r31 = 0;
    for (int i = 0; i < 5; i++) begin
      pc = 32'(i * 4); alu = 32'(i + 100); md = 32'(i + 200); sreg = 5'(i + 1);
      tick();
    end
    checkOutput("pre-reset pc", wb_pc, 32'h10);
    checkOutput("pre-reset count", wb_cnt, 5);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkModel("async reset");
    #1;
    rst = 1'b0;
    pc = 32'h40; alu = 32'h1234; md = 32'h5678; sreg = 9;
    tick();
    modelStep();
    checkOutput("post-reset pc", wb_pc, 32'h40);
    checkOutput("post-reset count", wb_cnt, 1);

    // Randomized run against the rule model.
    $display("[TB] randomized run");
    rst = 1'b1; #1; rst = 1'b0;
    modelReset();
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 4) == 0);
      v    = ($urandom_range(0, 4) != 0);
      h    = ($urandom_range(0, 29) == 0);
      md   = $urandom;
      alu  = $urandom;
      pc   = $urandom;
      sreg = 5'($urandom);
      rw   = 1'($urandom);
      m2r  = 1'($urandom);
      r31  = 1'($urandom);
      tick();
      modelStep();
      checkModel($sformatf("rand%0d", i));
      if (m.hd && $urandom_range(0, 3) == 0) begin
        rst = 1'b1; #1; rst = 1'b0;
        modelReset();
        checkModel($sformatf("rand%0d reset", i));
      end
    end

    // 4-bit counter saturates at 4'hF and stays there.
    $display("[TB] counter saturation");
    en = 1; fl = 0; v = 1; h = 0;
    rst_sat = 1'b0;
    #1;
    checkOutput("sat start", s_cnt, 0);
    for (int i = 1; i <= 17; i++) begin
      pc = 32'(i);
      tick();
      checkOutput($sformatf("sat capture%0d", i), s_cnt, (i > 15) ? 15 : i);
    end
    checkOutput("sat pc", s_pc, 32'd17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
